mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 65536: size of the shared RAM in bytes, a power of two.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive instruction-port denials that forces an instruction grant.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port i_req  in  1: instruction-fetch request.
REQ-006 SHALL have port i_addr  in  32: fetch byte address.
REQ-007 SHALL have ports i_gnt  out  1, i_rvalid  out  1, i_rdata  out  32: grant, read-data valid, read data.
REQ-008 SHALL have ports d_req  in  1, d_we  in  1, d_be  in  4, d_addr  in  32, d_wdata  in  32, d_lock  in  1: data request, write enable, byte enables, byte address, write data, lock.
REQ-009 SHALL have ports d_gnt  out  1, d_rvalid  out  1, d_rdata  out  32, d_err  out  1: grant, read valid, read data, error.
REQ-010 SHALL have ports m_en  out  1, m_we  out  4, m_addr  out  32, m_wdata  out  32, m_rdata  in  32: RAM port with 1-cycle read latency.

Function
REQ-011 SHALL grant at most one port per cycle; i_gnt and d_gnt are combinational from the requests and registered state.
REQ-012 SHALL give priority to d_req, unless the starvation count equals STARVE_LIMIT and i_req is high, in which case the instruction port wins.
REQ-013 SHALL increment the starvation count (saturating at STARVE_LIMIT) on each cycle with i_req high and i_gnt low, and clear it on i_gnt.
REQ-014 SHALL drive m_en, m_addr = {addr[31:2],2'b00}, m_wdata and m_we (d_be if d_we, else 0) from the winning port in the grant cycle; instruction reads use m_we = 0.
REQ-015 SHALL assert the winner's rvalid exactly one cycle after a read grant, with rdata = m_rdata; writes produce no rvalid.
REQ-016 SHALL implement a 2-state FSM: IDLE, LOCKED.
REQ-017 SHALL move IDLE->LOCKED when d_gnt is issued with d_lock = 1, and LOCKED->IDLE on the first cycle with d_lock = 0.
REQ-018 SHALL deny i_req in LOCKED regardless of the starvation count, while the count continues to saturate.
REQ-019 SHALL treat any address >= MEM_BYTES, or an instruction address with addr[1:0] != 0, as out of range: grant issued, m_en low, one cycle later rvalid = 1 with rdata = 0, and d_err = 1 for the data port only.
REQ-020 SHALL hold rdata outputs at 0 whenever the corresponding rvalid is low.
REQ-021 SHALL, when both ports request the same word in one cycle, serve only the winner; the loser is re-arbitrated the next cycle.

Reset
REQ-022 SHALL, while resetn is low, hold the FSM in IDLE, the starvation count at 0, and all outputs (gnt, rvalid, rdata, d_err, m_en, m_we, m_addr, m_wdata) at 0.
REQ-023 SHALL discard any read response in flight when reset asserts mid-transaction; no rvalid follows deassertion.
REQ-024 SHALL issue the first grant no earlier than the first rising clk edge after resetn deasserts.

Structure
REQ-025 SHALL take ADDR_W = 32, DATA_W = 32, the arb_state_t enum (IDLE, LOCKED) and the default MEM_BYTES from the shared core package twitch_pkg.
REQ-026 SHALL place the starvation counter in one sub-module, arb_starve_cnt, with inputs inc/clr and output at_limit.

Verification
REQ-027 SHALL cover: i_req only, i_addr = 0x100, m_rdata = 0x00000013 -> i_gnt in cycle N, i_rvalid = 1 and i_rdata = 0x13 in cycle N+1.
REQ-028 SHALL cover: i_req and d_req held high for 10 cycles (data reads) -> d_gnt on 4 cycles, then i_gnt on the 5th, repeating.
REQ-029 SHALL cover: data write d_addr = 0x202, d_be = 4'b0100, d_wdata = 0x00AB0000 -> m_we = 4'b0100, m_addr = 0x200, and no d_rvalid.
REQ-030 SHALL cover: d_lock held 8 cycles with i_req high -> zero i_gnt during the lock; i_gnt on the first cycle after d_lock falls.
REQ-031 SHALL cover: d_addr = MEM_BYTES -> d_gnt, m_en = 0, next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
REQ-032 SHALL cover: resetn pulled low the cycle after a read grant -> no rvalid, all outputs 0, FSM IDLE after release.

Source files
------------

// File: rtl/twitch_pkg.sv
// Shared core package: bus widths, arbiter state encoding, RAM request
// payload and the default shared-RAM size.
package twitch_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = DATA_W / 8;
    localparam int unsigned MEM_BYTES_DEF = 65536;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // One RAM-port transaction as presented in the grant cycle.
    typedef struct packed {
        logic              en;
        logic [BE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Word-aligned byte address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive instruction-port denials.
//   clk, resetn : clock, async active-low reset
//   inc         : instruction request denied this cycle
//   clr         : instruction request granted this cycle
//   at_limit    : count has reached LIMIT
module arb_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Counter saturates at LIMIT; a grant always restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single
// synchronous RAM with one cycle of read latency.
//   clk, resetn                 : clock, async active-low reset
//   i_req/i_addr                : instruction fetch request
//   i_gnt/i_rvalid/i_rdata      : fetch grant and read response
//   d_req/d_we/d_be/d_addr/
//   d_wdata/d_lock              : data request (lock holds off fetches)
//   d_gnt/d_rvalid/d_rdata/d_err: data grant, read response, range error
//   m_en/m_we/m_addr/m_wdata    : RAM request, driven in the grant cycle
//   m_rdata                     : RAM read data, valid one cycle later
module mem_arbiter
    import twitch_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = MEM_BYTES_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic [BE_W-1:0]   m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t state;
    logic       run;        // first edge after reset release has passed
    logic       at_limit;
    logic       lock_hold;
    logic       i_oor;
    logic       d_oor;
    logic       i_win;
    logic       d_win;
    logic       i_oor_q;
    mem_req_t   mreq;

    // A lock only blocks fetches while d_lock is still held; the release
    // cycle is already open to the instruction port.
    assign lock_hold = (state == LOCKED) && d_lock;

    assign i_oor = (i_addr >= ADDR_W'(MEM_BYTES)) || (i_addr[1:0] != 2'b00);
    assign d_oor = (d_addr >= ADDR_W'(MEM_BYTES));

    assign i_win = run && i_req && !lock_hold && (at_limit || !d_req);
    assign d_win = run && d_req && !i_win;

    assign i_gnt = i_win;
    assign d_gnt = d_win;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (i_req && !i_win),
        .clr      (i_win),
        .at_limit (at_limit)
    );

    // RAM request from the winner; out-of-range accesses never touch RAM.
    always_comb begin
        mreq = '0;
        if (i_win) begin
            mreq.en   = !i_oor;
            mreq.addr = word_align(i_addr);
        end else if (d_win) begin
            mreq.en    = !d_oor;
            mreq.we    = (d_we && !d_oor) ? d_be : '0;
            mreq.addr  = word_align(d_addr);
            mreq.wdata = d_wdata;
        end
    end

    assign m_en    = mreq.en;
    assign m_we    = mreq.we;
    assign m_addr  = mreq.addr;
    assign m_wdata = mreq.wdata;

    // Lock FSM plus response tracking; reset drops any read in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            run      <= 1'b0;
            i_rvalid <= 1'b0;
            i_oor_q  <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            run      <= 1'b1;
            i_rvalid <= i_win;
            i_oor_q  <= i_win && i_oor;
            d_rvalid <= d_win && (!d_we || d_oor);
            d_err    <= d_win && d_oor;
            case (state)
                IDLE:    if (d_win && d_lock) state <= LOCKED;
                LOCKED:  if (!d_lock)         state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data passes straight from RAM in the response cycle, else zero.
    assign i_rdata = (i_rvalid && !i_oor_q) ? m_rdata : '0;
    assign d_rdata = (d_rvalid && !d_err)   ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, a cycle-level reference model of
// the arbitration rules, directed scenarios and randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned MEM_BYTES = 65536;
    localparam int unsigned LIMIT     = 4;
    localparam int unsigned WORDS     = MEM_BYTES / 4;
    localparam int unsigned AW        = $clog2(MEM_BYTES);

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_lock;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_arbiter #(
        .MEM_BYTES    (MEM_BYTES),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_lock   (d_lock),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural RAM: byte-enable writes, registered read of the old word.
    logic [31:0] ram [WORDS];
    initial begin
        for (int w = 0; w < int'(WORDS); w++) ram[w] = init_word(w);
        ram[32'h100 >> 2] = 32'h00000013;
        forever begin
            @(posedge clk);
            if (m_en) begin
                m_rdata <= ram[m_addr[AW-1:2]];
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) ram[m_addr[AW-1:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: checks every output on every falling edge.
    logic [31:0] mmem [WORDS];
    int          scount;
    bit          mlock, mrun;
    bit          e_irv, e_drv, e_derr;
    logic [31:0] e_ird, e_drd;
    bit          wi, wd, ioor, door, een;
    logic [3:0]  ewe;
    logic [31:0] eaddr, ewd;

    initial begin
        for (int w = 0; w < int'(WORDS); w++) mmem[w] = init_word(w);
        mmem[32'h100 >> 2] = 32'h00000013;
        scount = 0; mlock = 0; mrun = 0;
        e_irv = 0; e_drv = 0; e_derr = 0; e_ird = '0; e_drd = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_i_gnt",    32'(i_gnt),    0);
                chk("rst_d_gnt",    32'(d_gnt),    0);
                chk("rst_i_rvalid", 32'(i_rvalid), 0);
                chk("rst_d_rvalid", 32'(d_rvalid), 0);
                chk("rst_i_rdata",  i_rdata,       0);
                chk("rst_d_rdata",  d_rdata,       0);
                chk("rst_d_err",    32'(d_err),    0);
                chk("rst_m_en",     32'(m_en),     0);
                chk("rst_m_we",     32'(m_we),     0);
                chk("rst_m_addr",   m_addr,        0);
                chk("rst_m_wdata",  m_wdata,       0);
                scount = 0; mlock = 0; mrun = 0;
                e_irv = 0; e_drv = 0; e_derr = 0; e_ird = '0; e_drd = '0;
            end else begin
                chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
                chk("i_rdata",  i_rdata,       e_ird);
                chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
                chk("d_rdata",  d_rdata,       e_drd);
                chk("d_err",    32'(d_err),    32'(e_derr));

                // Who may win: data first, unless the fetch side has been
                // starved long enough and no lock is being held.
                wi = mrun && i_req && !(mlock && d_lock) && (!d_req || scount == int'(LIMIT));
                wd = mrun && d_req && !wi;
                ioor = (i_addr >= MEM_BYTES) || (i_addr % 4 != 0);
                door = (d_addr >= MEM_BYTES);
                een = 0; ewe = '0; eaddr = '0; ewd = '0;
                if (wi) begin
                    een = !ioor; eaddr = i_addr & ~32'd3;
                end else if (wd) begin
                    een = !door; eaddr = d_addr & ~32'd3; ewd = d_wdata;
                    ewe = (d_we && !door) ? d_be : 4'b0000;
                end
                chk("i_gnt",   32'(i_gnt), 32'(wi));
                chk("d_gnt",   32'(d_gnt), 32'(wd));
                chk("m_en",    32'(m_en),  32'(een));
                chk("m_we",    32'(m_we),  32'(ewe));
                chk("m_addr",  m_addr,     eaddr);
                chk("m_wdata", m_wdata,    ewd);

                e_irv = wi;
                e_ird = (wi && !ioor) ? mmem[i_addr / 4] : 32'h0;
                e_drv = wd && (!d_we || door);
                e_derr = wd && door;
                e_drd = (wd && !d_we && !door) ? mmem[d_addr / 4] : 32'h0;
                if (wd && d_we && !door)
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) mmem[d_addr / 4][8*b +: 8] = d_wdata[8*b +: 8];

                if (wi) scount = 0;
                else if (i_req && scount < int'(LIMIT)) scount++;
                if (mlock && !d_lock) mlock = 0;
                else if (!mlock && wd && d_lock) mlock = 1;
                mrun = 1;
            end
        end
    end

    task automatic idle_in();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; d_lock = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    bit lock_run;
    int r;

    initial begin
        resetn = 0;
        idle_in();
        i_req = 1; d_req = 1;
        repeat (3) next_cyc();
        @(negedge clk);
        chk("lit_rst_gnt", 32'({i_gnt, d_gnt}), 0);

        // Release with both requests up: nothing until the next edge.
        next_cyc();
        resetn = 1;
        @(negedge clk);
        chk("lit_release_no_gnt", 32'({i_gnt, d_gnt}), 0);
        next_cyc();
        @(negedge clk);
        chk("lit_first_d_gnt", 32'(d_gnt), 1);
        next_cyc();
        idle_in();

        // Single instruction fetch.
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        chk("lit_fetch_gnt",  32'(i_gnt), 1);
        chk("lit_fetch_addr", m_addr,     32'h100);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("lit_fetch_rvalid", 32'(i_rvalid), 1);
        chk("lit_fetch_rdata",  i_rdata,       32'h13);
        next_cyc();

        // Contention: four data grants then one fetch, repeating.
        for (int k = 0; k < 10; k++) begin
            i_req = 1; i_addr = 32'h104; d_req = 1; d_addr = 32'h300;
            @(negedge clk);
            chk("lit_starve_i_gnt", 32'(i_gnt), 32'(k % 5 == 4));
            chk("lit_starve_d_gnt", 32'(d_gnt), 32'(k % 5 != 4));
            next_cyc();
        end
        idle_in();
        next_cyc();

        // Byte write.
        d_req = 1; d_we = 1; d_addr = 32'h202; d_be = 4'b0100; d_wdata = 32'h00AB0000;
        @(negedge clk);
        chk("lit_wr_m_we",   32'(m_we), 32'h4);
        chk("lit_wr_m_addr", m_addr,    32'h200);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("lit_wr_no_rvalid", 32'(d_rvalid), 0);
        next_cyc();

        // Lock for 8 cycles with a waiting fetch.
        for (int k = 0; k < 8; k++) begin
            i_req = 1; i_addr = 32'h108; d_req = 1; d_addr = 32'h10; d_lock = 1;
            @(negedge clk);
            chk("lit_lock_no_i_gnt", 32'(i_gnt), 0);
            next_cyc();
        end
        d_lock = 0;
        @(negedge clk);
        chk("lit_unlock_i_gnt", 32'(i_gnt), 1);
        next_cyc();
        idle_in();
        next_cyc();

        // Out of range data read and misaligned fetch.
        d_req = 1; d_addr = MEM_BYTES;
        @(negedge clk);
        chk("lit_oor_d_gnt", 32'(d_gnt), 1);
        chk("lit_oor_m_en",  32'(m_en),  0);
        next_cyc();
        idle_in();
        i_req = 1; i_addr = 32'h102;
        @(negedge clk);
        chk("lit_oor_d_rvalid", 32'(d_rvalid), 1);
        chk("lit_oor_d_err",    32'(d_err),    1);
        chk("lit_oor_d_rdata",  d_rdata,       0);
        chk("lit_mis_i_gnt",    32'(i_gnt),    1);
        chk("lit_mis_m_en",     32'(m_en),     0);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("lit_mis_i_rvalid", 32'(i_rvalid), 1);
        chk("lit_mis_i_rdata",  i_rdata,       0);
        chk("lit_mis_no_err",   32'(d_err),    0);
        next_cyc();

        // Reset with a locked read in flight.
        d_req = 1; d_lock = 1; d_addr = 32'h40;
        next_cyc();
        @(negedge clk);
        chk("lit_pre_rst_d_gnt", 32'(d_gnt), 1);
        next_cyc();
        resetn = 0;
        idle_in();
        @(negedge clk);
        chk("lit_midrst_d_rvalid", 32'(d_rvalid), 0);
        next_cyc();
        resetn = 1;
        @(negedge clk);
        chk("lit_after_rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);
        next_cyc();
        i_req = 1; i_addr = 32'h100; d_lock = 1;
        @(negedge clk);
        chk("lit_after_rst_idle", 32'(i_gnt), 1);
        next_cyc();
        idle_in();
        next_cyc();

        // Randomized traffic with occasional resets.
        lock_run = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(199) == 0) resetn = 0;
            else resetn = 1;
            i_req = ($urandom_range(2) != 0);
            r = int'($urandom_range(31));
            if (r == 0)     i_addr = MEM_BYTES + 32'($urandom_range(63)) * 4;
            else if (r < 3) i_addr = 32'($urandom_range(63)) * 4 + 32'($urandom_range(3, 1));
            else            i_addr = 32'($urandom_range(63)) * 4;
            d_req = ($urandom_range(2) != 0);
            d_we = ($urandom_range(2) == 0);
            d_be = 4'($urandom);
            d_wdata = $urandom;
            r = int'($urandom_range(31));
            if (r == 0)      d_addr = MEM_BYTES + 32'($urandom_range(255));
            else if (r == 1) d_addr = 32'hFFFFFFFC;
            else             d_addr = 32'($urandom_range(255));
            if ($urandom_range(5) == 0) lock_run = !lock_run;
            d_lock = lock_run;
            next_cyc();
        end
        idle_in();
        resetn = 1;
        repeat (2) next_cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
